i2c_arb2202: RTL

Two-requester round-robin arbiter and transaction sequencer that shares one `i2c_ctrl2202` I2C master between two on-chip clients. It latches one client's command (address, direction, write byte) and launches it on the master. It then tracks the master's busy phases to detect completion, and returns read data with a done or error pulse to the owning client. It sits between the client logic and the I2C master, in the same `i_cclk` domain.

---
 rtl/i2c_arb2202.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/i2c_arb2202.sv
// Two-client round-robin arbiter and transaction sequencer in front of one i2c_ctrl2202 master.
// Optional per-transaction watchdog: define I2C_ARB_TIMEOUT_EN (limit set by TIMEOUT_CYC).

module i2c_arb2202 #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        i_cclk,
  input  logic        i_rst,
  input  logic [1:0]  i_req,
  input  logic [1:0]  i_rd,
  input  logic [13:0] i_addr,
  input  logic [15:0] i_wdata,
  output logic [1:0]  o_gnt,
  output logic [1:0]  o_done,
  output logic [1:0]  o_err,
  output logic [7:0]  o_rdata,
  output logic        o_m_start,
  output logic        o_m_read,
  output logic [6:0]  o_m_address,
  output logic [7:0]  o_m_txdata,
  input  logic        i_m_busy,
  input  logic [7:0]  i_m_rxdata
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    ADDR_PH = 3'd2,
    DATA_PH = 3'd3,
    FINISH  = 3'd4
  } state_t;

  state_t     state_reg, state_next;
  logic       sel_reg;
  logic       last_reg;
  logic       busy_prev_reg;
  logic       m_read_reg;
  logic [6:0] m_address_reg;
  logic [7:0] m_txdata_reg;
  logic [7:0] rdata_reg;

  logic       pick;
  logic       req_any;
  logic       busy_fall;
  logic       timeout;
  logic       err_flag;
  logic       rdata_load;
  logic [1:0] sel_onehot;
  logic [6:0] addr_arr  [2];
  logic [7:0] wdata_arr [2];

  if ((TIMEOUT_CYC < 2) || (TIMEOUT_CYC > 255)) begin : g_bad_timeout
    $error("i2c_arb2202: TIMEOUT_CYC must lie within 2..255");
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_client
    assign addr_arr[gi]  = i_addr[7*gi +: 7];
    assign wdata_arr[gi] = i_wdata[8*gi +: 8];
  end

  // On a tie the client that was not served last wins.
  always_comb begin
    pick = 1'b0;
    case (i_req)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~last_reg;
      default: pick = 1'b0;
    endcase
  end

  assign req_any    = |i_req;
  assign busy_fall  = busy_prev_reg & ~i_m_busy;
  assign sel_onehot = {sel_reg, ~sel_reg};
  assign rdata_load = (state_reg == FINISH) && m_read_reg && !err_flag;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam logic [7:0] WDOG_LIMIT = 8'(TIMEOUT_CYC - 1);

  logic [7:0] wdog_reg;
  logic       err_flag_reg;

  // Counter value including the current cycle is compared, so FINISH lands TIMEOUT_CYC cycles after LAUNCH.
  assign timeout  = ((wdog_reg + 8'd1) == WDOG_LIMIT);
  assign err_flag = err_flag_reg;

  always_ff @(posedge i_cclk) begin
    if (i_rst) begin
      wdog_reg     <= 8'd0;
      err_flag_reg <= 1'b0;
    end else begin
      case (state_reg)
        LAUNCH: begin
          wdog_reg     <= 8'd0;
          err_flag_reg <= 1'b0;
        end
        ADDR_PH, DATA_PH: begin
          wdog_reg <= wdog_reg + 8'd1;
          if (timeout && !busy_fall) begin
            err_flag_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
`else
  assign timeout  = 1'b0;
  assign err_flag = 1'b0;
`endif

  always_ff @(posedge i_cclk) begin
    if (i_rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // A busy edge always takes precedence over a watchdog expiry in the same cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_any) state_next = LAUNCH;
      LAUNCH:  state_next = ADDR_PH;
      ADDR_PH: begin
        if (busy_fall)    state_next = DATA_PH;
        else if (timeout) state_next = FINISH;
      end
      DATA_PH: if (busy_fall || timeout) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_gnt     = 2'b00;
    o_done    = 2'b00;
    o_err     = 2'b00;
    o_m_start = 1'b0;
    if (state_reg != IDLE) begin
      o_gnt = sel_onehot;
    end
    if (state_reg == LAUNCH) begin
      o_m_start = 1'b1;
    end
    if (state_reg == FINISH) begin
      if (err_flag) o_err  = sel_onehot;
      else          o_done = sel_onehot;
    end
  end

  // Read byte is forwarded during FINISH so it is valid alongside the done pulse.
  assign o_rdata     = rdata_load ? i_m_rxdata : rdata_reg;
  assign o_m_read    = m_read_reg;
  assign o_m_address = m_address_reg;
  assign o_m_txdata  = m_txdata_reg;

  always_ff @(posedge i_cclk) begin
    if (i_rst) begin
      sel_reg       <= 1'b0;
      last_reg      <= 1'b1;
      busy_prev_reg <= 1'b0;
      m_read_reg    <= 1'b0;
      m_address_reg <= 7'd0;
      m_txdata_reg  <= 8'd0;
      rdata_reg     <= 8'd0;
    end else begin
      busy_prev_reg <= (state_reg == LAUNCH) ? 1'b0 : i_m_busy;
      if ((state_reg == IDLE) && req_any) begin
        sel_reg       <= pick;
        m_read_reg    <= i_rd[pick];
        m_address_reg <= addr_arr[pick];
        m_txdata_reg  <= wdata_arr[pick];
      end
      if (state_reg == FINISH) begin
        last_reg <= sel_reg;
      end
      if (rdata_load) begin
        rdata_reg <= i_m_rxdata;
      end
    end
  end

endmodule
